commit_trace_buffer: RTL and testbench
======================================

Name: commit_trace_buffer

Overview:
- Sits directly downstream of the riscv datapath top and consumes its per-cycle retire outputs: PC_Output, Instruction and Result.
- Captures those outputs into a FIFO under control of a small arm/trigger FSM.
- Drains entries over a valid/ready port to the simulation logger or a debug UART.
- Gives the team a cycle-exact commit trace without dumping full VCDs.

Parameters:
DEPTH, 16, FIFO entries; power of two, ≥2
PC_W, 64, PC width
INSTR_W, 32, instruction width
DATA_W, 64, result width
CNT_W, 8, width of post_count

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
commit_valid  in  1  datapath retired an instruction this cycle
pc_in  in  PC_W  PC_Output of the retiring instruction
instr_in  in  INSTR_W  Instruction of the retiring instruction
result_in  in  DATA_W  Result of the retiring instruction
arm  in  1  single-cycle pulse: start a capture session
disarm  in  1  single-cycle pulse: stop capture, return to IDLE
flush  in  1  single-cycle pulse: empty the FIFO
trig_en  in  1  1 = wait for trig_pc before capturing; 0 = capture immediately
trig_pc  in  PC_W  trigger address
post_count  in  CNT_W  entries to capture, trigger entry included; 0 = unlimited
out_valid  out  1  head entry available
out_ready  in  1  consumer accepts head entry
out_pc  out  PC_W  head entry PC
out_instr  out  INSTR_W  head entry instruction
out_result  out  DATA_W  head entry result
level  out  $clog2(DEPTH)+1  number of stored entries
drop_cnt  out  16  commits lost because the FIFO was full; saturates at 16'hFFFF
state  out  2  FSM state: 0 IDLE, 1 WAIT_TRIG, 2 CAPTURE, 3 DONE

Behaviour:
- Reset (reset=0, asynchronous), all outputs:
  - state=IDLE; FIFO empty; level=0; drop_cnt=0.
  - out_valid=0; out_pc, out_instr, out_result all 0.
- FSM transitions, evaluated at each rising edge:
  - disarm → IDLE from any state. disarm has priority over arm in the same cycle.
  - IDLE or DONE, arm: → WAIT_TRIG if trig_en=1, else → CAPTURE.
  - post_count and trig_pc are sampled into internal registers on the arm edge.
  - WAIT_TRIG, commit_valid && pc_in==trig_pc: → CAPTURE, and this commit is itself captured.
  - CAPTURE: each accepted capture increments a session counter.
  - CAPTURE with sampled post_count≠0: after the post_count-th capture → DONE on that edge.
  - CAPTURE with sampled post_count=0: stays in CAPTURE indefinitely.
  - arm while in WAIT_TRIG or CAPTURE is ignored.
  - DONE holds until arm or disarm. The FIFO is not flushed by re-arm.
- Capture condition: commit_valid, and (state==CAPTURE, or state==WAIT_TRIG with a trigger hit this cycle).
- FIFO push:
  - Accepted when not full, or when full with a pop in the same cycle.
  - If full without a pop, the commit is dropped and drop_cnt increments.
  - Dropped commits still count toward post_count.
- FIFO pop and head outputs:
  - A pop occurs when out_valid && out_ready.
  - Show-ahead: out_* always present the head entry; out_valid = (level≠0).
  - When empty, out_* hold their last value.
- Latency: an entry pushed at edge N is visible on out_* with out_valid=1 after edge N. A push into an empty FIFO therefore gives one cycle of latency.
- Push and pop in the same cycle: level is unchanged. Pointers wrap modulo DEPTH.
- flush:
  - Clears pointers, level and drop_cnt on the next edge.
  - Does not change state.
  - A push in the same cycle is discarded; flush wins.
- Arithmetic:
  - level and the session counter are unsigned.
  - The session counter is CNT_W bits and compares for equality with the sampled post_count.
- Reset asserted mid-session: immediate return to the reset values above; FIFO contents are lost.

Optional Feature:
- Macro TRACE_NOP_FILTER_EN.
- Defined:
  - Commits with instr_in==32'h00000013 (addi x0,x0,0) are never pushed.
  - They do not count toward post_count or drop_cnt.
  - They can still fire the trigger.
- Undefined: every commit is treated identically.

Decomposition:
- Package trace_pkg holds:
  - the state encoding constants (ST_IDLE, ST_WAIT_TRIG, ST_CAPTURE, ST_DONE);
  - NOP_INSTR=32'h00000013;
  - the packed entry struct {pc, instr, result}.
- One sub-module, trace_fifo: parametric show-ahead synchronous FIFO with push, pop, flush, full, empty and level.
- The FSM, counters and drop logic live in the top module.

Test Plan:
- Free-run: trig_en=0, post_count=0, arm; 5 commits PC 0x0,0x4,…,0x10 with out_ready=1 → 5 entries out in order, each one cycle after its push; level returns to 0; state stays CAPTURE.
- Trigger: trig_en=1, trig_pc=0x20, post_count=3, arm; commits PC 0x0..0x40 step 4 → only PCs 0x20, 0x24, 0x28 captured; state=DONE on the 0x28 edge; later commits ignored.
- Overflow: DEPTH=16, out_ready=0, 20 commits in CAPTURE → level=16, drop_cnt=4; out_pc is the first PC; then a simultaneous push and pop while full → push accepted, level stays 16, drop_cnt stays 4.
- Flush and disarm: flush pulse with 8 stored entries and a concurrent push → level=0, drop_cnt=0, out_valid=0 next cycle; arm+disarm in the same cycle → state=IDLE.
- Async reset: pull reset low mid-CAPTURE with level=5, between clock edges → state=IDLE, level=0, out_valid=0 immediately, before the next edge.
- TRACE_NOP_FILTER_EN defined: post_count=2; commit sequence NOP, 0x00500093, NOP, 0x00a00113 → only the two non-NOP entries are stored; state=DONE after the second one.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types for the commit trace buffer: FSM encoding, NOP pattern, entry layout.
// Optional build macro TRACE_NOP_FILTER_EN is consumed by commit_trace_buffer.
package trace_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_TRIG = 2'd1,
      ST_CAPTURE   = 2'd2,
      ST_DONE      = 2'd3
   } trace_state_e;

   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   localparam int TRACE_PC_W    = 64;
   localparam int TRACE_INSTR_W = 32;
   localparam int TRACE_DATA_W  = 64;

   // Entry layout at the default widths, as seen by the logger / UART side.
   typedef struct packed {
      logic [TRACE_PC_W-1:0]    pc;
      logic [TRACE_INSTR_W-1:0] instr;
      logic [TRACE_DATA_W-1:0]  result;
   } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead synchronous FIFO with flush. The head is presented combinationally;
// while empty the output holds the last head that was shown.
module trace_fifo #(
   parameter  int DEPTH = 16,
   parameter  int W     = 160,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic          flush,
   input  logic [W-1:0]  din,
   output logic [W-1:0]  dout,
   output logic          full,
   output logic          empty,
   output logic [LW-1:0] level
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] cnt;
   logic [W-1:0]  last_q;
   logic          do_push, do_pop;

   assign empty   = (cnt == '0);
   assign full    = (cnt == LW'(DEPTH));
   assign do_pop  = pop && !empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_push = push && !flush && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         last_q <= '0;
      end else begin
         if (!empty) last_q <= mem[rd_ptr];
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
               2'b10:   cnt <= cnt + LW'(1);
               2'b01:   cnt <= cnt - LW'(1);
               default: cnt <= cnt;
            endcase
         end
      end
   end

   assign dout  = empty ? last_q : mem[rd_ptr];
   assign level = cnt;

endmodule

// File: rtl/commit_trace_buffer.sv
// Arm/trigger controlled capture of retire outputs into a show-ahead FIFO.
// Build macro TRACE_NOP_FILTER_EN: drop canonical NOPs from the trace.
module commit_trace_buffer
   import trace_pkg::*;
#(
   parameter  int DEPTH   = 16,
   parameter  int PC_W    = TRACE_PC_W,
   parameter  int INSTR_W = TRACE_INSTR_W,
   parameter  int DATA_W  = TRACE_DATA_W,
   parameter  int CNT_W   = 8,
   localparam int LW      = $clog2(DEPTH) + 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               commit_valid,
   input  logic [PC_W-1:0]    pc_in,
   input  logic [INSTR_W-1:0] instr_in,
   input  logic [DATA_W-1:0]  result_in,
   input  logic               arm,
   input  logic               disarm,
   input  logic               flush,
   input  logic               trig_en,
   input  logic [PC_W-1:0]    trig_pc,
   input  logic [CNT_W-1:0]   post_count,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [PC_W-1:0]    out_pc,
   output logic [INSTR_W-1:0] out_instr,
   output logic [DATA_W-1:0]  out_result,
   output logic [LW-1:0]      level,
   output logic [15:0]        drop_cnt,
   output logic [1:0]         state
);

   typedef struct packed {
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
      logic [DATA_W-1:0]  result;
   } entry_t;

   trace_state_e     state_q, state_d;
   logic [CNT_W-1:0] post_q, sess_q;
   logic [PC_W-1:0]  trig_pc_q;
   logic             is_nop, trig_hit, capture, last_cap, arm_ok;
   logic             pop, full, empty;
   entry_t           din, dout;

`ifdef TRACE_NOP_FILTER_EN
   assign is_nop = (instr_in == INSTR_W'(NOP_INSTR));
`else
   assign is_nop = 1'b0;
`endif

   // A NOP may still fire the trigger; it is simply not stored or counted.
   assign trig_hit = (state_q == ST_WAIT_TRIG) && commit_valid && (pc_in == trig_pc_q);
   assign capture  = commit_valid && !is_nop && ((state_q == ST_CAPTURE) || trig_hit);
   assign last_cap = capture && (post_q != '0) && ((sess_q + CNT_W'(1)) == post_q);
   assign arm_ok   = arm && !disarm && ((state_q == ST_IDLE) || (state_q == ST_DONE));
   assign pop      = !empty && out_ready;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (disarm) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: if (arm)      state_d = trig_en ? ST_WAIT_TRIG : ST_CAPTURE;
            ST_WAIT_TRIG:     if (trig_hit) state_d = last_cap ? ST_DONE : ST_CAPTURE;
            ST_CAPTURE:       if (last_cap) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
         endcase
      end
   end

   // Session counter counts every capture attempt, dropped or not.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         post_q    <= '0;
         trig_pc_q <= '0;
         sess_q    <= '0;
         drop_cnt  <= '0;
      end else begin
         if (arm_ok) begin
            post_q    <= post_count;
            trig_pc_q <= trig_pc;
            sess_q    <= '0;
         end else if (capture) begin
            sess_q <= sess_q + CNT_W'(1);
         end
         if (flush)
            drop_cnt <= '0;
         else if (capture && full && !pop && (drop_cnt != 16'hFFFF))
            drop_cnt <= drop_cnt + 16'd1;
      end
   end

   assign din.pc     = pc_in;
   assign din.instr  = instr_in;
   assign din.result = result_in;

   trace_fifo #(
      .DEPTH (DEPTH),
      .W     ($bits(entry_t))
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (capture),
      .pop   (pop),
      .flush (flush),
      .din   (din),
      .dout  (dout),
      .full  (full),
      .empty (empty),
      .level (level)
   );

   assign out_valid  = !empty;
   assign out_pc     = dout.pc;
   assign out_instr  = dout.instr;
   assign out_result = dout.result;
   assign state      = state_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer with a FIFO-order scoreboard on the drain port.
module tb_commit_trace_buffer;

   localparam int DEPTH = 16;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        commit_valid = 1'b0;
   logic [63:0] pc_in = '0;
   logic [31:0] instr_in = '0;
   logic [63:0] result_in = '0;
   logic        arm = 1'b0, disarm = 1'b0, flush = 1'b0, trig_en = 1'b0;
   logic [63:0] trig_pc = '0;
   logic [7:0]  post_count = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] out_pc;
   logic [31:0] out_instr;
   logic [63:0] out_result;
   logic [LW-1:0] level;
   logic [15:0] drop_cnt;
   logic [1:0]  state;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
      logic [63:0] result;
   } ent_t;

   ent_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   commit_trace_buffer #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .commit_valid (commit_valid),
      .pc_in        (pc_in),
      .instr_in     (instr_in),
      .result_in    (result_in),
      .arm          (arm),
      .disarm       (disarm),
      .flush        (flush),
      .trig_en      (trig_en),
      .trig_pc      (trig_pc),
      .post_count   (post_count),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_pc       (out_pc),
      .out_instr    (out_instr),
      .out_result   (out_result),
      .level        (level),
      .drop_cnt     (drop_cnt),
      .state        (state)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ins_of(input logic [63:0] pc);
      return 32'h1000_0000 | pc[31:0];
   endfunction

   function automatic logic [63:0] res_of(input logic [63:0] pc);
      return {pc[31:0] ^ 32'hA5A5_0000, ~pc[31:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [63:0] pc, input logic [31:0] ins, input bit keep);
      ent_t e;
      commit_valid = 1'b1;
      pc_in        = pc;
      instr_in     = ins;
      result_in    = res_of(pc);
      e.pc = pc; e.instr = ins; e.result = res_of(pc);
      if (keep) exp_q.push_back(e);
   endtask

   task automatic do_arm(input logic te, input logic [63:0] tpc, input logic [7:0] pcnt);
      trig_en = te; trig_pc = tpc; post_count = pcnt;
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   // Scoreboard: every accepted head must match the oldest expected entry.
   always @(negedge clk) begin
      if (reset && out_valid && out_ready) begin
         vectors++;
         assert (exp_q.size() != 0) else begin
            miscompares++;
            $error("FAIL pop_unexpected: observed pc %0h expected no entry", out_pc);
         end
         if (exp_q.size() != 0) begin
            ent_t e;
            e = exp_q.pop_front();
            check("sb_pc", out_pc, e.pc);
            check("sb_instr", {32'h0, out_instr}, {32'h0, e.instr});
            check("sb_result", out_result, e.result);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed no finish expected finish");
      $fatal(1);
   end

   initial begin
      #12;
      check("rst_state", state, 0);
      check("rst_level", level, 0);
      check("rst_drop", drop_cnt, 0);
      check("rst_valid", out_valid, 0);
      check("rst_pc", out_pc, 0);
      check("rst_instr", out_instr, 0);
      check("rst_result", out_result, 0);
      @(posedge clk); #1;
      reset = 1'b1;
      tick();

      // Free-run capture
      out_ready = 1'b1;
      do_arm(1'b0, 64'h0, 8'd0);
      check("fr_state", state, 2);
      for (int i = 0; i < 5; i++) begin
         drive(64'(4 * i), ins_of(64'(4 * i)), 1'b1);
         tick();
         check("fr_valid", out_valid, 1);
         check("fr_pc", out_pc, 64'(4 * i));
      end
      commit_valid = 1'b0;
      tick();
      check("fr_level", level, 0);
      check("fr_state_end", state, 2);

      // Trigger capture of three entries
      disarm = 1'b1; tick(); disarm = 1'b0;
      check("dis_state", state, 0);
      do_arm(1'b1, 64'h20, 8'd3);
      trig_pc = 64'h0; post_count = 8'd0;
      check("tr_state_wait", state, 1);
      for (int pc = 0; pc <= 'h40; pc += 4) begin
         drive(64'(pc), ins_of(64'(pc)), (pc >= 'h20) && (pc <= 'h28));
         tick();
         if (pc == 'h20) check("tr_state_cap", state, 2);
         if (pc == 'h28) check("tr_state_done", state, 3);
      end
      commit_valid = 1'b0;
      tick();
      check("tr_level", level, 0);
      check("tr_state_hold", state, 3);

      // Overflow with consumer stalled
      out_ready = 1'b0;
      do_arm(1'b0, 64'h0, 8'd0);
      check("ov_state", state, 2);
      for (int i = 0; i < 20; i++) begin
         drive(64'h100 + 64'(4 * i), ins_of(64'h100 + 64'(4 * i)), i < 16);
         tick();
      end
      commit_valid = 1'b0;
      check("ov_level", level, 16);
      check("ov_drop", drop_cnt, 4);
      check("ov_head", out_pc, 64'h100);
      drive(64'h200, ins_of(64'h200), 1'b1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      commit_valid = 1'b0;
      check("ov_pp_level", level, 16);
      check("ov_pp_drop", drop_cnt, 4);
      check("ov_pp_head", out_pc, 64'h104);

      // Flush and disarm
      flush = 1'b1; tick(); flush = 1'b0;
      exp_q.delete();
      check("fl_level", level, 0);
      check("fl_drop", drop_cnt, 0);
      check("fl_valid", out_valid, 0);
      check("fl_hold_pc", out_pc, 64'h104);
      for (int i = 0; i < 8; i++) begin
         drive(64'h400 + 64'(4 * i), ins_of(64'h400 + 64'(4 * i)), 1'b1);
         tick();
      end
      commit_valid = 1'b0;
      check("fl_level8", level, 8);
      drive(64'h500, ins_of(64'h500), 1'b0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      commit_valid = 1'b0;
      exp_q.delete();
      check("fl2_level", level, 0);
      check("fl2_drop", drop_cnt, 0);
      check("fl2_valid", out_valid, 0);
      check("fl2_state", state, 2);
      disarm = 1'b1; tick(); disarm = 1'b0;
      check("dis2_state", state, 0);
      arm = 1'b1; disarm = 1'b1;
      tick();
      arm = 1'b0; disarm = 1'b0;
      check("armdis_state", state, 0);

      // Asynchronous reset mid-session
      do_arm(1'b0, 64'h0, 8'd0);
      for (int i = 0; i < 5; i++) begin
         drive(64'h600 + 64'(4 * i), ins_of(64'h600 + 64'(4 * i)), 1'b1);
         tick();
      end
      commit_valid = 1'b0;
      check("ar_level5", level, 5);
      check("ar_state_cap", state, 2);
      #3;
      reset = 1'b0;
      #1;
      check("ar_state", state, 0);
      check("ar_level", level, 0);
      check("ar_valid", out_valid, 0);
      check("ar_pc", out_pc, 0);
      check("ar_drop", drop_cnt, 0);
      exp_q.delete();
      @(posedge clk); #1;
      reset = 1'b1;
      tick();

`ifdef TRACE_NOP_FILTER_EN
      do_arm(1'b0, 64'h0, 8'd2);
      drive(64'h300, 32'h0000_0013, 1'b0);
      tick();
      check("nop_level0", level, 0);
      drive(64'h304, 32'h0050_0093, 1'b1);
      tick();
      check("nop_level1", level, 1);
      check("nop_state1", state, 2);
      drive(64'h308, 32'h0000_0013, 1'b0);
      tick();
      check("nop_level1b", level, 1);
      check("nop_state1b", state, 2);
      drive(64'h30c, 32'h00a0_0113, 1'b1);
      tick();
      commit_valid = 1'b0;
      check("nop_level2", level, 2);
      check("nop_state_done", state, 3);
`endif

      // Drain whatever the scoreboard still expects
      out_ready = 1'b1;
      for (int n = 0; n < 40 && exp_q.size() != 0; n++) tick();
      tick();
      out_ready = 1'b0;
      check("drain_level", level, 0);
      check("drain_sb_left", 64'(exp_q.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
